// File: rtl/execute.sv
// Accumulator execute stage: two-state opcode/immediate decoder driving an 8-bit
// accumulator, 4-entry register file, Z/C flags and the branch redirect into fetch.
module execute (
   input  logic       clk,
   input  logic       sync_rst,
   input  logic [7:0] word,
   output logic [7:0] branch_wr,
   output logic       branch_wr_en,
   output logic [7:0] acc,
   output logic       flag_z,
   output logic       flag_c,
   output logic       halted,
   output logic       retire
);
   typedef enum logic [1:0] {S_SKIP, S_OPCODE, S_IMM, S_HALT} state_t;

   state_t     state, state_nx;
   logic [3:0] op_q;
   logic [7:0] rf [4];

   logic [3:0] op;
   logic [7:0] operand;
   logic       two_byte;
   logic       jump_taken;

   assign op       = word[7:4];
   assign operand  = rf[word[1:0]];
   assign two_byte = (op == 4'h1) || (op == 4'hA) || (op == 4'hB) || (op == 4'hC);

   always_comb begin
      case (op_q)
         4'hA:    jump_taken = 1'b1;
         4'hB:    jump_taken = flag_z;
         4'hC:    jump_taken = flag_c;
         default: jump_taken = 1'b0;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (sync_rst) state <= S_SKIP;
      else          state <= state_nx;
   end

   // next state
   always_comb begin
      state_nx = state;
      case (state)
         S_SKIP:   state_nx = S_OPCODE;
         S_OPCODE: begin
            if (op == 4'hF)    state_nx = S_HALT;
            else if (two_byte) state_nx = S_IMM;
         end
         S_IMM:    state_nx = jump_taken ? S_SKIP : S_OPCODE;
         S_HALT:   state_nx = S_HALT;
         default:  state_nx = S_SKIP;
      endcase
   end

   // outputs and datapath controls; everything is forced idle while in reset
   logic       acc_we, z_we, c_we, rf_we, op_we, halt_set;
   logic [8:0] alu;

   always_comb begin
      retire       = 1'b0;
      branch_wr_en = 1'b0;
      branch_wr    = 8'h00;
      acc_we       = 1'b0;
      z_we         = 1'b0;
      c_we         = 1'b0;
      rf_we        = 1'b0;
      op_we        = 1'b0;
      halt_set     = 1'b0;
      alu          = {1'b0, acc};
      if (!sync_rst) begin
         case (state)
            S_OPCODE: begin
               if (two_byte) op_we = 1'b1;
               else          retire = 1'b1;
               case (op)
                  4'h2: rf_we = 1'b1;
                  4'h3: begin alu = {1'b0, operand}; acc_we = 1'b1; z_we = 1'b1; end
                  4'h4: begin alu = {1'b0, acc} + {1'b0, operand}; acc_we = 1'b1; z_we = 1'b1; c_we = 1'b1; end
                  // borrow lands in bit 8 of the 9-bit difference
                  4'h5: begin alu = {1'b0, acc} - {1'b0, operand}; acc_we = 1'b1; z_we = 1'b1; c_we = 1'b1; end
                  4'h6: begin alu = {1'b0, acc & operand}; acc_we = 1'b1; z_we = 1'b1; end
                  4'h7: begin alu = {1'b0, acc | operand}; acc_we = 1'b1; z_we = 1'b1; end
                  4'h8: begin alu = {1'b0, acc ^ operand}; acc_we = 1'b1; z_we = 1'b1; end
                  4'h9: begin alu = {1'b0, acc} + {5'b0, word[3:0]}; acc_we = 1'b1; z_we = 1'b1; c_we = 1'b1; end
                  4'hF: halt_set = 1'b1;
                  default: ;
               endcase
            end
            S_IMM: begin
               retire = 1'b1;
               if (op_q == 4'h1) begin
                  alu    = {1'b0, word};
                  acc_we = 1'b1;
                  z_we   = 1'b1;
               end else if (jump_taken) begin
                  branch_wr_en = 1'b1;
                  branch_wr    = word;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         acc    <= 8'h00;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         halted <= 1'b0;
         op_q   <= 4'h0;
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else begin
         if (acc_we)   acc          <= alu[7:0];
         if (z_we)     flag_z       <= (alu[7:0] == 8'h00);
         if (c_we)     flag_c       <= alu[8];
         if (rf_we)    rf[word[1:0]] <= acc;
         if (op_we)    op_q         <= op;
         if (halt_set) halted       <= 1'b1;
      end
   end
endmodule

// File: tb/tb_execute.sv
// Directed bench for execute: vector table with per-cycle expectations, plus
// hand sequences for a fetch-attached redirect and reset mid-instruction.
module tb_execute;
   logic       clk = 1'b0;
   logic       sync_rst = 1'b1;
   logic [7:0] drv_word = 8'hF0;
   logic       use_fetch = 1'b0;
   logic [7:0] word;
   logic [7:0] branch_wr, acc;
   logic       branch_wr_en, flag_z, flag_c, halted, retire;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   execute dut (
      .clk          (clk),
      .sync_rst     (sync_rst),
      .word         (word),
      .branch_wr    (branch_wr),
      .branch_wr_en (branch_wr_en),
      .acc          (acc),
      .flag_z       (flag_z),
      .flag_c       (flag_c),
      .halted       (halted),
      .retire       (retire)
   );

   // simple fetch: registered output, pc reloaded on redirect
   logic [7:0] mem [256];
   logic [7:0] pc = 8'h00;
   logic [7:0] fword = 8'hF0;
   always @(posedge clk) begin
      if (sync_rst) pc <= 8'h00;
      else begin
         fword <= mem[pc];
         pc    <= branch_wr_en ? branch_wr : pc + 8'h01;
      end
   end
   assign word = use_fetch ? fword : drv_word;

   typedef struct {
      bit         rst;
      logic [7:0] w;
      logic       ret, br;
      logic [7:0] bwr, acc;
      logic       z, c, h;
   } vec_t;

   function automatic vec_t mk(bit rst, logic [7:0] w, logic ret, logic br, logic [7:0] bwr,
                               logic [7:0] a, logic z, logic c, logic h);
      vec_t v;
      v.rst = rst; v.w = w; v.ret = ret; v.br = br; v.bwr = bwr;
      v.acc = a; v.z = z; v.c = c; v.h = h;
      return v;
   endfunction

   task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      use_fetch = 1'b0;
      sync_rst  = 1'b1;
      drv_word  = 8'hF0;
      #1 chk("rst_bren", {7'b0, branch_wr_en}, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_acc", acc, 8'h00);
      chk("rst_z", {7'b0, flag_z}, 8'h00);
      chk("rst_c", {7'b0, flag_c}, 8'h00);
      chk("rst_halted", {7'b0, halted}, 8'h00);
      chk("rst_retire", {7'b0, retire}, 8'h00);
   endtask

   task automatic apply(vec_t v, int idx);
      string s;
      if (v.rst) do_reset();
      @(negedge clk);
      sync_rst = 1'b0;
      drv_word = v.w;
      #1;
      s = $sformatf("v%0d", idx);
      chk({s, "_retire"}, {7'b0, retire}, {7'b0, v.ret});
      chk({s, "_bren"}, {7'b0, branch_wr_en}, {7'b0, v.br});
      chk({s, "_bwr"}, branch_wr, v.bwr);
      @(posedge clk);
      #1;
      chk({s, "_acc"}, acc, v.acc);
      chk({s, "_z"}, {7'b0, flag_z}, {7'b0, v.z});
      chk({s, "_c"}, {7'b0, flag_c}, {7'b0, v.c});
      chk({s, "_halted"}, {7'b0, halted}, {7'b0, v.h});
   endtask

   vec_t tbl[$];

   initial begin
      int n_br, n_ret;
      bit done;

      // LDI 0xFF ; ADDI 1 -> wrap to 0 with carry
      tbl.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 8'hFF, 0, 0, 0));
      tbl.push_back(mk(0, 8'h91, 1, 0, 8'h00, 8'h00, 1, 1, 0));
      // LDI 5 ; MOV r2 ; LDI 3 ; SUB r2 (borrow) ; LDR r2
      tbl.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h05, 1, 0, 8'h00, 8'h05, 0, 0, 0));
      tbl.push_back(mk(0, 8'h22, 1, 0, 8'h00, 8'h05, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h05, 0, 0, 0));
      tbl.push_back(mk(0, 8'h03, 1, 0, 8'h00, 8'h03, 0, 0, 0));
      tbl.push_back(mk(0, 8'h52, 1, 0, 8'h00, 8'hFE, 0, 1, 0));
      tbl.push_back(mk(0, 8'h32, 1, 0, 8'h00, 8'h05, 0, 1, 0));
      // JZ not taken, then JZ taken with squash of the shadow byte
      tbl.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'hB0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h20, 1, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h33, 1, 0, 8'h00, 8'h33, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h33, 0, 0, 0));
      tbl.push_back(mk(0, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'hB0, 0, 0, 8'h00, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'h20, 1, 1, 8'h20, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 1, 0, 0));
      tbl.push_back(mk(0, 8'h55, 1, 0, 8'h00, 8'h55, 0, 0, 0));
      // HLT ignores everything after it
      tbl.push_back(mk(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 0));
      tbl.push_back(mk(0, 8'h07, 1, 0, 8'h00, 8'h07, 0, 0, 0));
      tbl.push_back(mk(0, 8'hF0, 1, 0, 8'h00, 8'h07, 0, 0, 1));
      tbl.push_back(mk(0, 8'h11, 0, 0, 8'h00, 8'h07, 0, 0, 1));
      tbl.push_back(mk(0, 8'h77, 0, 0, 8'h00, 8'h07, 0, 0, 1));

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

      // reset in the IMM cycle of an LDI drops the immediate and re-enters SKIP
      apply(mk(1, 8'hF0, 0, 0, 8'h00, 8'h00, 0, 0, 0), 100);
      apply(mk(0, 8'h11, 0, 0, 8'h00, 8'h00, 0, 0, 0), 101);
      apply(mk(0, 8'h07, 1, 0, 8'h00, 8'h07, 0, 0, 0), 102);
      apply(mk(0, 8'h11, 0, 0, 8'h00, 8'h07, 0, 0, 0), 103);
      @(negedge clk);
      sync_rst = 1'b1;
      drv_word = 8'h42;
      #1 chk("midimm_retire", {7'b0, retire}, 8'h00);
      @(posedge clk);
      #1 chk("midimm_acc", acc, 8'h00);
      apply(mk(0, 8'h91, 0, 0, 8'h00, 8'h00, 0, 0, 0), 104);
      apply(mk(0, 8'h91, 1, 0, 8'h00, 8'h01, 0, 0, 0), 105);

      // reset held over a JMP address byte suppresses the redirect
      apply(mk(0, 8'hA0, 0, 0, 8'h00, 8'h01, 0, 0, 0), 106);
      @(negedge clk);
      sync_rst = 1'b1;
      drv_word = 8'h10;
      #1;
      chk("rstjmp_bren", {7'b0, branch_wr_en}, 8'h00);
      chk("rstjmp_bwr", branch_wr, 8'h00);
      @(posedge clk);

      // fetch-attached: JMP 0x10 over a shadow LDI, then LDI 0x42 ; HLT
      for (int a = 0; a < 256; a++) mem[a] = 8'h00;
      mem[8'h00] = 8'hA0; mem[8'h01] = 8'h10; mem[8'h02] = 8'h11; mem[8'h03] = 8'h99;
      mem[8'h10] = 8'h11; mem[8'h11] = 8'h42; mem[8'h12] = 8'hF0;
      do_reset();
      @(negedge clk);
      sync_rst  = 1'b0;
      use_fetch = 1'b1;
      n_br  = 0;
      n_ret = 0;
      done  = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         #1;
         if (halted) done = 1'b1;
         else begin
            if (retire) n_ret++;
            if (branch_wr_en) begin
               n_br++;
               chk("fetch_bwr", branch_wr, 8'h10);
            end
            @(negedge clk);
         end
      end
      chk("fetch_halted", {7'b0, done}, 8'h01);
      chk("fetch_br_count", n_br[7:0], 8'h01);
      chk("fetch_retire_count", n_ret[7:0], 8'h03);
      chk("fetch_acc", acc, 8'h42);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/execute.md
# execute

Single-issue accumulator execute stage that sits directly downstream of the fetch stage. It consumes one fetched instruction byte per cycle, runs a small two-state opcode/immediate decoder, and updates an 8-bit accumulator, a 4-entry register file and Z/C flags. It drives the branch redirect back into fetch and squashes the wrong-path byte that is already in flight.

## Interface
- No parameters. The data width is 8 and the register file depth is 4, both fixed.
- clk  in  1  the single clock; all state changes on the rising edge.
- sync_rst  in  1  synchronous, active-high reset.
- word  in  8  instruction byte from fetch; this is fetch's registered output.
- branch_wr  out  8  redirect target; equals word while branch_wr_en=1, otherwise 8'h00.
- branch_wr_en  out  1  redirect request to fetch; combinational and single-cycle.
- acc  out  8  accumulator.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/borrow flag.
- halted  out  1  high once HLT has executed.
- retire  out  1  one-cycle pulse on the cycle an instruction completes (the opcode cycle for 1-byte instructions, the immediate cycle for 2-byte ones).

## Operation
- Encoding: op=word[7:4], r=word[1:0], n=word[3:0].
  - 0x0 NOP.
  - 0x1 LDI: next byte -> acc.
  - 0x2 MOV: reg[r] <= acc.
  - 0x3 LDR: acc <= reg[r].
  - 0x4 ADD: acc += reg[r].
  - 0x5 SUB: acc -= reg[r].
  - 0x6 AND, 0x7 OR, 0x8 XOR: acc op= reg[r].
  - 0x9 ADDI: acc += {4'b0,n}.
  - 0xA JMP addr.
  - 0xB JZ addr (taken if Z=1).
  - 0xC JC addr (taken if C=1).
  - 0xD, 0xE: NOP.
  - 0xF HLT.
- Two-byte instructions: LDI, JMP, JZ, JC. All others are one byte.
- Flags:
  - Z <= (new acc == 0) on LDI, LDR, ADD, SUB, AND, OR, XOR, ADDI.
  - C <= 9th bit of the sum on ADD/ADDI. On SUB, C <= (acc < reg[r]) as an unsigned borrow.
  - All other instructions leave the flags unchanged.
- Arithmetic is mod 256, and the result is truncated to 8 bits.
- State machine:
  - SKIP: word is discarded and the next state is OPCODE. Entered on reset and after every taken branch.
  - OPCODE: decode word.
    - 1-byte instruction: execute, pulse retire, stay in OPCODE.
    - 2-byte instruction: latch op, go to IMM.
    - HLT: pulse retire, go to HALT.
  - IMM: word is the immediate.
    - LDI: load acc, retire, go to OPCODE.
    - Jump taken: branch_wr_en=1, branch_wr=word, retire, go to SKIP.
    - Jump not taken: retire, go to OPCODE.
  - HALT: word is ignored, all outputs are held, halted=1. Exit is by reset only.
- The execute stage itself never stalls. Every cycle consumes exactly one word.

## Timing
- Reset values (sync_rst high at an edge): state=SKIP, acc=0, reg[0..3]=0, Z=0, C=0, halted=0, retire=0.
- While sync_rst is high, branch_wr_en=0 and branch_wr=0, forced combinationally.
- After reset: the first word sampled after sync_rst falls is fetch's stale output register, and it is discarded (SKIP). The byte at address 0x00 arrives on the following cycle.
- Redirect latency:
  - branch_wr_en is asserted in the same cycle the jump's address byte is present, and fetch loads pc at that edge.
  - The next word is the byte fetched from the old pc+1. That byte is squashed in SKIP, with no register, flag or retire effect.
  - The target byte is decoded in the second cycle after the redirect.
- branch_wr_en is never asserted in two consecutive cycles.
- Register effects are visible on acc/flag outputs one edge after the deciding cycle.
- Reset mid-operation (IMM, SKIP or HALT): the latched op and the pending immediate are dropped and reset values apply.
- A 2-byte opcode followed by the end of the program has no special case; the next byte is always taken as the immediate.

## Test plan
- Reset: hold sync_rst 3 cycles with word=8'hF0, then release with word=8'hF0 for one cycle -> the byte is discarded (halted stays 0, retire=0), and acc=0, Z=0, C=0.
- Word stream 0x11,0xFF,0x91 -> acc=0xFF, then acc=0x00 with Z=1, C=1. retire pulses twice.
- Word stream 0x11,0x05,0x22,0x11,0x03,0x52 -> reg[2]=0x05, final acc=0xFE, C=1, Z=0.
- With fetch and memory attached, mem[0..]=0xA0,0x10,0x11 and mem[0x10]=0x11,0x42:
  - branch_wr_en high for exactly one cycle with branch_wr=0x10.
  - The shadow LDI at 0x02 is not executed.
  - Final acc=0x42.
- JZ 0x20 executed with Z=0 -> no branch_wr_en and the following byte decodes normally. Repeat with Z=1 -> branch taken to 0x20.
- HLT then 0x11,0x77 -> halted=1 and acc unchanged. Then assert sync_rst in the middle of the IMM of an LDI -> acc=0, state SKIP, and the immediate is dropped.
